axi_lite_write_arb: RTL and testbench
=====================================

Name: axi_lite_write_arb

Overview:
- Parametrised AXI-Lite write master serving NUM_REQ requesters.
- Arbitrates between requesters, then issues one single-beat AW/W write at a time.
- Waits for the B response before acknowledging the write, and returns BRESP to the requester that won.
- Sits between control-side agents (maestro, FSMs, DMA-like engines) and the peripheral AXI-Lite crossbar. Supersedes fixed two-port write masters.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 is highest priority in fixed mode; legal range 1..16.
- ADDR_W, 32, address width; must match axi_master.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- ARB_MODE, 0, arbitration mode: 0 = fixed priority, 1 = round-robin.
- TIMEOUT_CYCLES, 256, watchdog limit; only used when AXI_WRITE_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- axi_master  master  AXI_LITE  write channels AW, W, B; AR/R tied idle
- req_i  in  NUM_REQ  per-requester write request, level, held until ack
- addr_i  in  NUM_REQ x ADDR_W  per-requester write address
- data_i  in  NUM_REQ x DATA_W  per-requester write data
- strb_i  in  NUM_REQ x DATA_W/8  per-requester byte strobes
- ack_o  out  NUM_REQ  one-cycle completion pulse, one-hot
- resp_o  out  2  BRESP of the completed write; valid while any ack_o bit is high
- busy_o  out  1  high in any state other than IDLE
- timeout_o  out  1  watchdog expiry pulse; tied 0 when the macro is off

Behaviour:
- Reset (rst_n low at a clk edge):
  - aw_valid, w_valid, b_ready, ack_o, busy_o, timeout_o all 0.
  - aw_addr, w_data, w_strb = 0; resp_o = 2'b00.
  - Grant index and round-robin pointer = 0; state = IDLE.
- Reset mid-transaction: all valids drop at that edge. No ack is issued and the in-flight write is abandoned.
- FSM states: IDLE -> SEND -> RESP -> ACK -> IDLE.
- IDLE:
  - req_i is sampled only in this state.
  - If any bit is set, the arbiter picks a winner, and its addr/data/strb are latched into aw_addr/w_data/w_strb.
  - aw_valid and w_valid go high on the next cycle (state SEND).
  - Changes to the winner's inputs after latching are ignored.
- SEND:
  - aw_valid drops on the cycle after the AW handshake; w_valid drops on the cycle after the W handshake. The two are independent and may occur in either order or the same cycle.
  - Valids never drop before their handshake.
  - Once both handshakes are done, the next state is RESP.
- RESP: b_ready = 1. On the B handshake, resp_o latches b_resp, b_ready drops, and the next state is ACK.
- ACK:
  - ack_o[grant] = 1 for exactly one cycle; the next state is IDLE.
  - Requesters deassert req_i no later than the cycle after ack. A req still high in IDLE is treated as a new write.
- Minimum latency with ready/valid always asserted by the slave: req cycle 0, valids cycle 1, b_ready cycle 2, ack cycle 3, next grant decided cycle 4.
- Arbitration:
  - ARB_MODE=0: lowest set index wins.
  - ARB_MODE=1: first set index at or after the pointer wins, with wrap-around from NUM_REQ-1 to 0. The pointer moves to grant+1 (mod NUM_REQ) in ACK.
  - NUM_REQ=1: grant is always 0.
- Simultaneous requests: exactly one winner; losers keep req_i high and are served later. No ack ever goes to a non-granted index.

Optional Feature:
- Macro: AXI_WRITE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to SEND and increments every cycle in SEND/RESP.
  - When it reaches TIMEOUT_CYCLES: aw_valid, w_valid and b_ready drop, resp_o = 2'b10 (SLVERR), timeout_o pulses one cycle together with ack_o[grant], and the FSM goes via ACK to IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: no counter; the FSM waits indefinitely; timeout_o is constant 0.

Decomposition:
- Package axi_lite_write_pkg holds:
  - the state enum (IDLE, SEND, RESP, ACK);
  - the ARB_MODE constants ARB_FIXED=0 and ARB_RR=1;
  - the BRESP constants OKAY=2'b00 and SLVERR=2'b10.
- One sub-module, req_arbiter: combinational one-hot grant from req vector, mode and pointer. It is reusable by the read-side successor.

Test Plan:
- NUM_REQ=2, ARB_MODE=0, both req high, addr0=0x1000/data0=0xAAAA0001, addr1=0x2000/data1=0xBBBB0002, slave always ready, BRESP=OKAY -> first write 0x1000, ack_o=2'b01 at cycle 3; then 0x2000, ack_o=2'b10; resp_o=00 for both.
- ARB_MODE=1, NUM_REQ=4, all req held high -> grant order 0,1,2,3,0; each ack one-hot and one cycle wide.
- Slave delays aw_ready 3 cycles and asserts w_ready immediately -> w_valid low after cycle 1, aw_valid held until its handshake, b_ready only after both, ack exactly once.
- Slave returns BRESP=2'b10 with strb=4'b0011 -> w_strb=0011 on the bus; resp_o=10 during ack.
- rst_n asserted while in SEND -> next cycle all valids 0, no ack_o, busy_o=0, next request restarts from IDLE.
- AXI_WRITE_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts b_valid -> timeout_o and ack_o pulse 16 cycles after SEND entry, resp_o=10, b_ready=0.

Source files
------------

// File: rtl/axi_lite_write_pkg.sv
// Shared types and constants for the AXI-Lite write arbiter and its request arbiter.
package axi_lite_write_pkg;

   typedef enum logic [1:0] {StIdle, StSend, StResp, StAck} wr_state_e;

   localparam int unsigned ARB_FIXED = 0;
   localparam int unsigned ARB_RR    = 1;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // Index width that stays legal for a single requester.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/req_arbiter.sv
// Combinational one-hot arbiter: fixed priority (index 0 first) or round-robin from ptr.
module req_arbiter
   import axi_lite_write_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned PTR_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic               rr_mode,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic [PTR_W-1:0]     base;
   logic [2*NUM_REQ-1:0] rot2;
   logic [2*NUM_REQ-1:0] pick2;
   logic [NUM_REQ-1:0]   rot;
   logic [NUM_REQ-1:0]   pick;

   // Rotate so the pointer position is bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      base  = rr_mode ? ptr : '0;
      rot2  = {req, req} >> base;
      rot   = rot2[NUM_REQ-1:0];
      pick  = rot & (~rot + {{(NUM_REQ-1){1'b0}}, 1'b1});
      pick2 = {{NUM_REQ{1'b0}}, pick} << base;
      grant = pick2[NUM_REQ-1:0] | pick2[2*NUM_REQ-1:NUM_REQ];
   end

endmodule

// File: rtl/axi_lite_write_arb.sv
// Multi-requester AXI-Lite single-beat write master; one write in flight at a time.
// Optional watchdog enabled by defining AXI_WRITE_TIMEOUT_EN.
module axi_lite_write_arb
   import axi_lite_write_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned ARB_MODE       = 0,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                                clk,
   input  logic                                rst_n,
   output logic [ADDR_W-1:0]                   aw_addr,
   output logic                                aw_valid,
   input  logic                                aw_ready,
   output logic [DATA_W-1:0]                   w_data,
   output logic [DATA_W/8-1:0]                 w_strb,
   output logic                                w_valid,
   input  logic                                w_ready,
   input  logic [1:0]                          b_resp,
   input  logic                                b_valid,
   output logic                                b_ready,
   output logic [ADDR_W-1:0]                   ar_addr,
   output logic                                ar_valid,
   output logic                                r_ready,
   input  logic [NUM_REQ-1:0]                  req_i,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]      addr_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]      data_i,
   input  logic [NUM_REQ-1:0][DATA_W/8-1:0]    strb_i,
   output logic [NUM_REQ-1:0]                  ack_o,
   output logic [1:0]                          resp_o,
   output logic                                busy_o,
   output logic                                timeout_o
);

   localparam int unsigned PTR_W  = idx_width(NUM_REQ);
   localparam int unsigned STRB_W = DATA_W / 8;

   wr_state_e            state_q;
   logic [PTR_W-1:0]     grant_q;
   logic [PTR_W-1:0]     rr_ptr_q;
   logic [NUM_REQ-1:0]   grant_oh;
   logic [PTR_W-1:0]     grant_idx;
   logic [ADDR_W-1:0]    win_addr;
   logic [DATA_W-1:0]    win_data;
   logic [STRB_W-1:0]    win_strb;
   logic                 aw_done;
   logic                 w_done;
   logic [NUM_REQ-1:0]   grant_ack;

   assign ar_addr  = '0;
   assign ar_valid = 1'b0;
   assign r_ready  = 1'b0;

   req_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_req_arbiter (
      .req     (req_i),
      .rr_mode (ARB_MODE == ARB_RR),
      .ptr     (rr_ptr_q),
      .grant   (grant_oh)
   );

   always_comb begin
      grant_idx = '0;
      win_addr  = '0;
      win_data  = '0;
      win_strb  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_oh[k]) begin
            grant_idx = PTR_W'(k);
            win_addr  = addr_i[k];
            win_data  = data_i[k];
            win_strb  = strb_i[k];
         end
      end
   end

   // A channel is finished once its valid has already dropped or is handshaking now.
   assign aw_done   = !aw_valid || aw_ready;
   assign w_done    = !w_valid || w_ready;
   assign grant_ack = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;

`ifdef AXI_WRITE_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt_q;
`else
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         aw_addr  <= '0;
         aw_valid <= 1'b0;
         w_data   <= '0;
         w_strb   <= '0;
         w_valid  <= 1'b0;
         b_ready  <= 1'b0;
         ack_o    <= '0;
         resp_o   <= OKAY;
         busy_o   <= 1'b0;
`ifdef AXI_WRITE_TIMEOUT_EN
         timeout_o <= 1'b0;
         tmo_cnt_q <= '0;
`endif
      end else begin
         ack_o <= '0;
`ifdef AXI_WRITE_TIMEOUT_EN
         timeout_o <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (|req_i) begin
                  grant_q  <= grant_idx;
                  aw_addr  <= win_addr;
                  w_data   <= win_data;
                  w_strb   <= win_strb;
                  aw_valid <= 1'b1;
                  w_valid  <= 1'b1;
                  busy_o   <= 1'b1;
                  state_q  <= StSend;
`ifdef AXI_WRITE_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end
            end
            StSend: begin
               if (aw_valid && aw_ready) aw_valid <= 1'b0;
               if (w_valid && w_ready) w_valid <= 1'b0;
               if (aw_done && w_done) begin
                  b_ready <= 1'b1;
                  state_q <= StResp;
               end
            end
            StResp: begin
               if (b_valid) begin
                  resp_o  <= b_resp;
                  b_ready <= 1'b0;
                  ack_o   <= grant_ack;
                  state_q <= StAck;
               end
            end
            StAck: begin
               busy_o   <= 1'b0;
               rr_ptr_q <= (grant_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
               state_q  <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
`ifdef AXI_WRITE_TIMEOUT_EN
         // A B handshake landing on the expiry cycle still completes normally.
         if (state_q == StSend || state_q == StResp) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !(state_q == StResp && b_valid)) begin
               aw_valid  <= 1'b0;
               w_valid   <= 1'b0;
               b_ready   <= 1'b0;
               resp_o    <= SLVERR;
               ack_o     <= grant_ack;
               timeout_o <= 1'b1;
               state_q   <= StAck;
            end else begin
               tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_axi_lite_write_arb.sv
// Directed bench: fixed-priority 2-requester instance and round-robin 4-requester instance.
module tb_axi_lite_write_arb;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Shared slave responses
   logic       aw_ready, w_ready, b_valid;
   logic [1:0] b_resp;

   // Fixed-priority instance, NUM_REQ=2
   logic [1:0]         req_f, ack_f;
   logic [1:0][31:0]   addr_f, data_f;
   logic [1:0][3:0]    strb_f;
   logic [1:0]         resp_f;
   logic               busy_f, tmo_f;
   logic [31:0]        aw_addr_f, w_data_f, ar_addr_f;
   logic [3:0]         w_strb_f;
   logic               aw_valid_f, w_valid_f, b_ready_f, ar_valid_f, r_ready_f;

   // Round-robin instance, NUM_REQ=4
   logic [3:0]         req_r, ack_r;
   logic [3:0][31:0]   addr_r, data_r;
   logic [3:0][3:0]    strb_r;
   logic [1:0]         resp_r;
   logic               busy_r, tmo_r;
   logic [31:0]        aw_addr_r, w_data_r, ar_addr_r;
   logic [3:0]         w_strb_r;
   logic               aw_valid_r, w_valid_r, b_ready_r, ar_valid_r, r_ready_r;

   int checks = 0;
   int errors = 0;

   axi_lite_write_arb #(
      .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT_CYCLES(16)
   ) u_fix (
      .clk(clk), .rst_n(rst_n),
      .aw_addr(aw_addr_f), .aw_valid(aw_valid_f), .aw_ready(aw_ready),
      .w_data(w_data_f), .w_strb(w_strb_f), .w_valid(w_valid_f), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready_f),
      .ar_addr(ar_addr_f), .ar_valid(ar_valid_f), .r_ready(r_ready_f),
      .req_i(req_f), .addr_i(addr_f), .data_i(data_f), .strb_i(strb_f),
      .ack_o(ack_f), .resp_o(resp_f), .busy_o(busy_f), .timeout_o(tmo_f)
   );

   axi_lite_write_arb #(
      .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT_CYCLES(256)
   ) u_rr (
      .clk(clk), .rst_n(rst_n),
      .aw_addr(aw_addr_r), .aw_valid(aw_valid_r), .aw_ready(aw_ready),
      .w_data(w_data_r), .w_strb(w_strb_r), .w_valid(w_valid_r), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready_r),
      .ar_addr(ar_addr_r), .ar_valid(ar_valid_r), .r_ready(r_ready_r),
      .req_i(req_r), .addr_i(addr_r), .data_i(data_r), .strb_i(strb_r),
      .ack_o(ack_r), .resp_o(resp_r), .busy_o(busy_r), .timeout_o(tmo_r)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; sample and drive 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      logic [3:0] exp_rr [5];
      exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      rst_n = 1'b0;
      aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1; b_resp = 2'b00;
      req_f = '0; addr_f = '0; data_f = '0; strb_f = '0;
      req_r = '0; strb_r = '0;
      for (int i = 0; i < 4; i++) begin
         addr_r[i] = 32'h4000 + 32'(i) * 32'h10;
         data_r[i] = 32'hC000_0000 + 32'(i);
      end
      tick(); tick();
      chk("reset_ctrl_f", {aw_valid_f, w_valid_f, b_ready_f, busy_f, tmo_f, ack_f}, 7'b0);
      chk("reset_data_f", {aw_addr_f, w_data_f}, 64'h0);
      chk("reset_strb_resp_f", {w_strb_f, resp_f}, 6'b0);
      chk("reset_ctrl_r", {aw_valid_r, w_valid_r, b_ready_r, busy_r, ack_r}, 8'b0);
      rst_n = 1'b1;
      tick();

      // Fixed priority, both requesting, slave always ready
      addr_f[0] = 32'h1000; data_f[0] = 32'hAAAA0001; strb_f[0] = 4'hF;
      addr_f[1] = 32'h2000; data_f[1] = 32'hBBBB0002; strb_f[1] = 4'hF;
      req_f = 2'b11;                                              // cycle 0
      tick();                                                     // cycle 1
      chk("fix_c1_valids", {aw_valid_f, w_valid_f, b_ready_f, busy_f}, 4'b1101);
      chk("fix_c1_addr_data", {aw_addr_f, w_data_f}, {32'h1000, 32'hAAAA0001});
      tick();                                                     // cycle 2
      chk("fix_c2_bready", {aw_valid_f, w_valid_f, b_ready_f, ack_f}, 5'b00100);
      tick();                                                     // cycle 3
      chk("fix_c3_ack0", ack_f, 2'b01);
      chk("fix_c3_resp", resp_f, 2'b00);
      req_f = 2'b10;
      tick();                                                     // cycle 4
      chk("fix_c4_idle", {ack_f, busy_f}, 3'b000);
      tick();                                                     // cycle 5
      chk("fix_second_addr_data", {aw_addr_f, w_data_f}, {32'h2000, 32'hBBBB0002});
      tick(); tick();                                             // cycle 7
      chk("fix_ack1", ack_f, 2'b10);
      chk("fix_ack1_resp", resp_f, 2'b00);
      req_f = 2'b00;
      tick();
      chk("fix_ack1_width", ack_f, 2'b00);
      tick();

      // Round-robin, all four requesting continuously
      req_r = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         w = 0;
         while (ack_r == 4'b0 && w < 12) begin
            tick();
            w++;
         end
         chk("rr_grant_order", ack_r, exp_rr[n]);
         if (n == 4) req_r = 4'b0000;
         tick();
         chk("rr_ack_width", ack_r, 4'b0000);
      end
      w = 0;
      while (busy_r && w < 10) begin
         tick();
         w++;
      end
      chk("rr_idle_after", busy_r, 1'b0);
      tick();

      // AW delayed three cycles, W immediate
      aw_ready = 1'b0; b_valid = 1'b0;
      addr_f[0] = 32'h3000; data_f[0] = 32'h1234_5678;
      req_f = 2'b01;                                              // cycle 0
      tick();                                                     // cycle 1
      chk("dly_c1_valids", {aw_valid_f, w_valid_f}, 2'b11);
      tick();                                                     // cycle 2
      chk("dly_c2_w_dropped", {aw_valid_f, w_valid_f, b_ready_f}, 3'b100);
      tick();                                                     // cycle 3
      chk("dly_c3_aw_held", {aw_valid_f, w_valid_f, b_ready_f}, 3'b100);
      aw_ready = 1'b1;
      tick();                                                     // cycle 4
      chk("dly_c4_aw_hs", {aw_valid_f, b_ready_f, ack_f}, 4'b0100);
      b_valid = 1'b1;
      tick();                                                     // cycle 5
      chk("dly_ack", ack_f, 2'b01);
      req_f = 2'b00;
      tick();
      chk("dly_ack_once", {ack_f, b_ready_f}, 3'b000);
      tick(); tick();
      chk("dly_no_extra_ack", {ack_f, busy_f}, 3'b000);

      // SLVERR response with partial strobes
      b_resp = 2'b10;
      addr_f[1] = 32'h2004; strb_f[1] = 4'b0011;
      req_f = 2'b10;
      tick();
      chk("err_strb_on_bus", w_strb_f, 4'b0011);
      tick(); tick();
      chk("err_ack_resp", {ack_f, resp_f}, 4'b1010);
      req_f = 2'b00;
      b_resp = 2'b00;
      tick(); tick();

      // Reset while in SEND
      aw_ready = 1'b0; w_ready = 1'b0;
      addr_f[0] = 32'h5000;
      req_f = 2'b01;
      tick();
      chk("rst_in_send", {aw_valid_f, w_valid_f, busy_f}, 3'b111);
      rst_n = 1'b0;
      tick();
      chk("rst_all_low", {aw_valid_f, w_valid_f, b_ready_f, busy_f, ack_f}, 6'b0);
      rst_n = 1'b1; aw_ready = 1'b1; w_ready = 1'b1;
      tick();
      chk("rst_restart", {aw_valid_f, aw_addr_f}, {1'b1, 32'h5000});
      tick(); tick();
      chk("rst_restart_ack", ack_f, 2'b01);
      req_f = 2'b00;
      tick(); tick();

`ifdef AXI_WRITE_TIMEOUT_EN
      // Slave never answers B
      b_valid = 1'b0;
      req_f = 2'b01;                                              // cycle 0
      tick();                                                     // cycle 1: SEND entry
      req_f = 2'b01;
      for (int c = 2; c <= 16; c++) tick();                       // cycle 16
      chk("tmo_not_yet", {ack_f, tmo_f}, 3'b000);
      tick();                                                     // cycle 17
      chk("tmo_pulse", {ack_f, tmo_f, resp_f, b_ready_f}, 6'b01_1_10_0);
      req_f = 2'b00;
      tick();
      chk("tmo_pulse_width", {ack_f, tmo_f}, 3'b000);
      b_valid = 1'b1;
`else
      chk("tmo_tied_low", tmo_f, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
